// File: rtl/sw_conditioner.sv
// Board slide-switch front end: synchronise and debounce SW[15:0], then decode them into
// CPU go/reset/step-enable controls, LED display mode and RAM display address.
module sw_conditioner #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned DIV_WIDTH       = 24,
   parameter int unsigned ADDR_BITS       = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          sw_raw,
   output logic [15:0]          sw_stable,
   output logic                 go,
   output logic                 cpu_rst,
   output logic                 cpu_clk_en,
   output logic [2:0]           display_op,
   output logic [ADDR_BITS-3:0] ram_display_addr
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned AW    = ADDR_BITS - 2;

   localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_WIDTH-1:0] MASK_LOW  = DIV_WIDTH'(15);
   localparam logic [DIV_WIDTH-1:0] MASK_MID  = DIV_WIDTH'((64'd1 << (DIV_WIDTH / 2)) - 64'd1);
   localparam logic [DIV_WIDTH-1:0] MASK_FULL = '1;

   logic [SYNC_STAGES-1:0][15:0] r_sync;
   logic [15:0][CNT_W-1:0]       r_db_cnt;
   logic [15:0]                  r_sw_stable;
   logic [2:0]                   r_por_cnt;
   logic                         r_cpu_rst;
   logic [DIV_WIDTH-1:0]         r_div;
   logic                         r_clk_en;
   logic                         r_go;
   logic                         r_sw0_q;
   logic [2:0]                   r_display_op;
   logic [AW-1:0]                r_ram_addr;

   logic [15:0]          w_s;
   logic [DIV_WIDTH-1:0] w_mask;
   logic                 w_cpu_rst_d;
   logic                 w_div_hit;
   logic                 w_sw0_rise;

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync      <= '0;
         r_db_cnt    <= '0;
         r_sw_stable <= '0;
      end else begin
         r_sync[0] <= sw_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
         for (int i = 0; i < 16; i++) begin
            if (w_s[i] == r_sw_stable[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == CNT_MAX) begin
               r_sw_stable[i] <= w_s[i];
               r_db_cnt[i]    <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_mask = '0;
      case (r_sw_stable[3:2])
         2'b00:   w_mask = '0;
         2'b01:   w_mask = MASK_LOW;
         2'b10:   w_mask = MASK_MID;
         default: w_mask = MASK_FULL;
      endcase
   end

   assign w_cpu_rst_d = (r_por_cnt != 3'd7) | r_sw_stable[1];
   assign w_div_hit   = (r_div & w_mask) == w_mask;
   assign w_sw0_rise  = r_sw_stable[0] & ~r_sw0_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_por_cnt    <= '0;
         r_cpu_rst    <= 1'b1;
         r_div        <= '0;
         r_clk_en     <= 1'b0;
         r_go         <= 1'b0;
         r_sw0_q      <= 1'b0;
         r_display_op <= '0;
         r_ram_addr   <= '0;
      end else begin
         if (r_por_cnt != 3'd7) begin
            r_por_cnt <= r_por_cnt + 3'd1;
         end
         r_cpu_rst <= w_cpu_rst_d;
         r_div     <= r_div + DIV_WIDTH'(1);
         // Gated by both current and next reset so the enable never overlaps cpu_rst.
         r_clk_en  <= w_div_hit & ~r_cpu_rst & ~w_cpu_rst_d;
         r_sw0_q   <= r_sw_stable[0];

         if (r_cpu_rst) begin
            r_go <= 1'b0;
         end else if (w_sw0_rise) begin
            r_go <= 1'b1;
         end else if (r_go && r_clk_en) begin
            r_go <= 1'b0;
         end

         r_display_op <= r_sw_stable[6:4];
         r_ram_addr   <= AW'(r_sw_stable[15:7]);
      end
   end

   assign sw_stable        = r_sw_stable;
   assign go               = r_go;
   assign cpu_rst          = r_cpu_rst;
   assign cpu_clk_en       = r_clk_en;
   assign display_op       = r_display_op;
   assign ram_display_addr = r_ram_addr;

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed self-checking bench for sw_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, DIV_WIDTH=8).
module tb_sw_conditioner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] sw_raw = '0;
   logic [15:0] sw_stable;
   logic        go;
   logic        cpu_rst;
   logic        cpu_clk_en;
   logic [2:0]  display_op;
   logic [9:0]  ram_display_addr;

   int n_cmp  = 0;
   int n_fail = 0;

   sw_conditioner #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .DIV_WIDTH      (8),
      .ADDR_BITS      (12)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .sw_raw          (sw_raw),
      .sw_stable       (sw_stable),
      .go              (go),
      .cpu_rst         (cpu_rst),
      .cpu_clk_en      (cpu_clk_en),
      .display_op      (display_op),
      .ram_display_addr(ram_display_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      logic exp_rst, exp_en;
      rst    = 1'b0;
      sw_raw = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst: got %b expected 1", cpu_rst); end
      n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL rst_go: got %b expected 0", go); end
      n_cmp++; if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL rst_clk_en: got %b expected 0", cpu_clk_en); end
      n_cmp++; if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL rst_sw_stable: got %h expected 0000", sw_stable); end
      n_cmp++; if (display_op !== 3'd0) begin n_fail++; $display("FAIL rst_display_op: got %0d expected 0", display_op); end
      n_cmp++; if (ram_display_addr !== 10'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 000", ram_display_addr); end
      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_rst = (k <= 7);
         exp_en  = (k >= 9);
         n_cmp++; if (cpu_rst !== exp_rst) begin n_fail++; $display("FAIL por_cpu_rst edge %0d: got %b expected %b", k, cpu_rst, exp_rst); end
         n_cmp++; if (cpu_clk_en !== exp_en) begin n_fail++; $display("FAIL por_clk_en edge %0d: got %b expected %b", k, cpu_clk_en, exp_en); end
      end
      n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL por_go: got %b expected 0", go); end
      n_cmp++; if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL por_sw_stable: got %h expected 0000", sw_stable); end
   endtask

   task automatic test_debounce();
      logic       exp_s;
      logic [2:0] exp_op;
      sw_raw[4] = 1'b1;
      ticks(3);
      sw_raw[4] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         n_cmp++; if (sw_stable[4] !== 1'b0 || display_op !== 3'd0) begin
            n_fail++; $display("FAIL glitch edge %0d: got stable4=%b op=%0d expected 0/0", k, sw_stable[4], display_op);
         end
      end
      sw_raw[4] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_s  = (k >= 6);
         exp_op = (k >= 7) ? 3'd1 : 3'd0;
         n_cmp++; if (sw_stable[4] !== exp_s) begin n_fail++; $display("FAIL debounce_stable edge %0d: got %b expected %b", k, sw_stable[4], exp_s); end
         n_cmp++; if (display_op !== exp_op) begin n_fail++; $display("FAIL debounce_op edge %0d: got %0d expected %0d", k, display_op, exp_op); end
      end
   endtask

   task automatic test_div_rates();
      logic [1:0] sel_tab [3] = '{2'b01, 2'b10, 2'b11};
      int         gap_tab [3] = '{16, 16, 256};
      int         wait_n, gap;
      for (int r = 0; r < 3; r++) begin
         sw_raw[3:2] = sel_tab[r];
         ticks(12);
         wait_n = 0;
         while (cpu_clk_en !== 1'b1 && wait_n < 300) begin tick(); wait_n++; end
         gap = 0;
         do begin tick(); gap++; end while (cpu_clk_en !== 1'b1 && gap < 600);
         n_cmp++; if (gap != gap_tab[r]) begin n_fail++; $display("FAIL div_gap sel=%b: got %0d expected %0d", sel_tab[r], gap, gap_tab[r]); end
         gap = 0;
         do begin tick(); gap++; end while (cpu_clk_en !== 1'b1 && gap < 600);
         n_cmp++; if (gap != gap_tab[r]) begin n_fail++; $display("FAIL div_gap2 sel=%b: got %0d expected %0d", sel_tab[r], gap, gap_tab[r]); end
      end
   endtask

   task automatic test_go_hold();
      int   n;
      logic exp_go, prev_en, done;
      sw_raw[3:2] = 2'b01;
      ticks(12);
      sw_raw[0] = 1'b1;
      n = 0;
      while (sw_stable[0] !== 1'b1 && n < 20) begin tick(); n++; end
      n_cmp++; if (n != 6) begin n_fail++; $display("FAIL go_sw0_latency: got %0d expected 6", n); end
      n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL go_early: got %b expected 0", go); end
      tick();
      n_cmp++; if (go !== 1'b1) begin n_fail++; $display("FAIL go_rise: got %b expected 1", go); end
      exp_go = 1'b1;
      done   = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         prev_en = cpu_clk_en;
         tick();
         if (prev_en) begin exp_go = 1'b0; done = 1'b1; end
         n_cmp++; if (go !== exp_go) begin n_fail++; $display("FAIL go_hold cycle %0d: got %b expected %b", c, go, exp_go); end
      end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL go_step_timeout: got no enable pulse expected one within 17"); end
      sw_raw[0] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL go_fall edge %0d: got %b expected 0", k, go); end
      end
   endtask

   task automatic test_reset_req();
      int n, en_cnt;
      sw_raw[0] = 1'b1;
      n = 0;
      while (go !== 1'b1 && n < 20) begin tick(); n++; end
      n_cmp++; if (go !== 1'b1) begin n_fail++; $display("FAIL req_go_arm: got %b expected 1", go); end
      sw_raw[1] = 1'b1;
      ticks(9);
      n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL req_cpu_rst: got %b expected 1", cpu_rst); end
      n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL req_go_clear: got %b expected 0", go); end
      en_cnt = 0;
      for (int k = 0; k < 40; k++) begin tick(); if (cpu_clk_en === 1'b1) en_cnt++; end
      n_cmp++; if (en_cnt != 0) begin n_fail++; $display("FAIL req_clk_en: got %0d pulses expected 0", en_cnt); end
      sw_raw[0] = 1'b0;
      ticks(10);
      sw_raw[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL req_go_suppress edge %0d: got %b expected 0", k, go); end
      end
      sw_raw[1:0] = 2'b00;
      ticks(10);
      n_cmp++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL req_release: got %b expected 0", cpu_rst); end
   endtask

   task automatic test_addr_async();
      sw_raw[15:7] = 9'h1A5;
      sw_raw[6:4]  = 3'b101;
      sw_raw[3:0]  = 4'b0000;
      ticks(10);
      n_cmp++; if (ram_display_addr !== 10'h1A5) begin n_fail++; $display("FAIL addr: got %h expected 1a5", ram_display_addr); end
      n_cmp++; if (display_op !== 3'd5) begin n_fail++; $display("FAIL addr_op: got %0d expected 5", display_op); end
      n_cmp++; if (sw_stable !== 16'hD2D0) begin n_fail++; $display("FAIL addr_stable: got %h expected d2d0", sw_stable); end
      n_cmp++; if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL addr_clk_en: got %b expected 1", cpu_clk_en); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL async_cpu_rst: got %b expected 1", cpu_rst); end
      n_cmp++; if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL async_clk_en: got %b expected 0", cpu_clk_en); end
      n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL async_go: got %b expected 0", go); end
      n_cmp++; if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL async_stable: got %h expected 0000", sw_stable); end
      n_cmp++; if (display_op !== 3'd0) begin n_fail++; $display("FAIL async_op: got %0d expected 0", display_op); end
      n_cmp++; if (ram_display_addr !== 10'h0) begin n_fail++; $display("FAIL async_addr: got %h expected 000", ram_display_addr); end
      ticks(2);
      rst = 1'b1;
      ticks(3);
      n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL restretch_cpu_rst: got %b expected 1", cpu_rst); end
      n_cmp++; if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL restretch_stable: got %h expected 0000", sw_stable); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_div_rates();
      test_go_hold();
      test_reset_req();
      test_addr_async();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sw_conditioner.md
Name: sw_conditioner

Overview:
- Front-end stage that turns the raw board slide switches into clean control for the CPU, RAM and LED blocks.
- Synchronises and debounces all 16 switches, then decodes them into the following outputs:
  - a held go request;
  - the CPU reset level;
  - a rate-selectable CPU clock-enable;
  - the display mode;
  - the RAM display address.
- Sits between the board SW pins and the CPU/RAM/LED instances in the top level.
- Produces a clock enable, never a derived clock.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per switch bit (>=2).
- DEBOUNCE_CYCLES, 16: consecutive disagreeing cycles before a stable bit flips. Board build uses 1000000.
- DIV_WIDTH, 24: width of the clock-enable divider counter (>=8).
- ADDR_BITS, 12: RAM byte-address bits. ram_display_addr is ADDR_BITS-2 wide (>=11).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sw_raw  in  16  unsynchronised board switches.
- sw_stable  out  16  debounced switch levels.
- go  out  1  held go request to CPU.
- cpu_rst  out  1  active-high reset level to CPU/RAM.
- cpu_clk_en  out  1  one-cycle CPU step enable.
- display_op  out  3  LED display mode.
- ram_display_addr  out  ADDR_BITS-2  word address for RAM display port.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync chain, debounce counters, divider, sw_stable, go, cpu_clk_en, display_op and ram_display_addr all clear to 0;
  - cpu_rst=1;
  - por_cnt (3 bits) clears to 0.
- Synchroniser: each bit passes through SYNC_STAGES flops; the last stage is s[i].
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES):
  - If s[i]==sw_stable[i]: counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1: sw_stable[i]<=s[i] and counter<=0.
  - Else: counter<=counter+1.
  - A raw change held steady reaches sw_stable exactly SYNC_STAGES+DEBOUNCE_CYCLES edges later.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Switch map (taken from sw_stable):
  - [0] = go switch;
  - [1] = CPU reset request;
  - [3:2] = speed select;
  - [6:4] = display_op (registered copy, 1 cycle after sw_stable);
  - [15:7] = ram_display_addr[8:0] (registered); upper bits of ram_display_addr are 0.
- Power-on reset stretch:
  - After rst release, por_cnt counts 0..7 and then saturates.
  - cpu_rst = (por_cnt!=7) | sw_stable[1], registered.
  - cpu_rst is therefore high for at least 8 cycles after rst release.
- Divider:
  - DIV_WIDTH-bit free-running counter, +1 every cycle, wraps to 0.
  - Mask per speed select:
    - sel 00: mask = 0 (cpu_clk_en every cycle);
    - sel 01: mask = 2^4-1;
    - sel 10: mask = 2^(DIV_WIDTH/2)-1;
    - sel 11: mask = 2^DIV_WIDTH-1.
  - cpu_clk_en (registered) = ((div & mask)==mask) & ~cpu_rst.
  - A speed change does not reset the divider; the new mask applies from the next compare.
  - cpu_clk_en is never high while cpu_rst=1.
- Go handshake. Edge detection on sw_stable[0] uses a delayed copy; rising-edge priority is highest:
  - Rising edge while cpu_rst=0 sets go=1.
  - go stays 1 through the first cycle with cpu_clk_en=1, then clears on the following edge. The CPU therefore sees go for exactly one enabled step.
  - A rising edge in the same cycle as the clearing cpu_clk_en re-arms go (go stays 1).
  - A falling edge of sw_stable[0] does not affect go.
  - cpu_rst=1 clears go and suppresses new edges.
- Reset mid-operation: asserting rst at any time clears all state immediately. The por stretch restarts on release.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, DIV_WIDTH=8):
- Reset / power-on stretch:
  - Stimulus: hold rst=0 for 3 cycles, release; sw_raw=0.
  - Required: cpu_rst=1 for 8 cycles after release, then 0.
  - Required: cpu_clk_en=0 while cpu_rst=1, then 1 every cycle (sel 00).
  - Required: go=0 and all other outputs 0.
- Debounce:
  - Stimulus: sw_raw[4] high for 3 cycles, then low.
  - Required: sw_stable[4] and display_op stay 0.
  - Stimulus: sw_raw[4] held high.
  - Required: sw_stable[4]=1 exactly 6 edges later; display_op=3'b001 one edge after that.
- Divider rates:
  - Stimulus: sel=01.
  - Required: cpu_clk_en high 1 cycle in 16.
  - Stimulus: sel=10.
  - Required: cpu_clk_en high 1 in 16 (DIV_WIDTH/2=4).
  - Stimulus: sel=11.
  - Required: cpu_clk_en high 1 in 256.
- Go hold:
  - Stimulus: sel=01; toggle SW[0] high.
  - Required: go rises 1 cycle after sw_stable[0] rises and holds until the next cpu_clk_en pulse (up to 16 cycles); it clears on the edge after that pulse.
  - Stimulus: toggle SW[0] low.
  - Required: no effect on go.
- Reset request:
  - Stimulus: SW[1]=1 while go=1.
  - Required: after debounce, cpu_rst=1, go clears, cpu_clk_en=0.
  - Stimulus: SW[0] edge while SW[1]=1.
  - Required: go stays 0.
- Address map and async reset:
  - Stimulus: SW[15:7]=9'h1A5.
  - Required: ram_display_addr=10'h1A5.
  - Stimulus: assert rst mid-count.
  - Required: all outputs return to reset values in the same cycle, without waiting for a clk edge.
